// File: rtl/exec_pkg.sv
// Shared encodings for the RV32 execute stage: ALU ops, forward selects,
// result-source selects and the iterative-multiplier state enum.
package exec_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_MUL = 3'b111;

    localparam logic [1:0] FWD_RD  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } mul_state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU: add, sub, and, or, signed slt, plus zero flag.
module alu_core
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [2:0]      op_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o
);

    logic slt_s;

    // Result select; unused opcodes (including mul) produce zero here.
    always_comb begin
        slt_s    = ($signed(a_i) < $signed(b_i));
        result_o = '0;
        case (op_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_SLT: result_o = {{(XLEN-1){1'b0}}, slt_s};
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/execute_stage.sv
// RV32 execute stage: operand forwarding, ALU, branch resolution and the E/M register.
// Define EXEC_MUL_EN to add the iterative shift-add multiplier (op 111) with stall request.
module execute_stage
    import exec_pkg::*;
#(
    parameter int PC_W = 5,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [PC_W-1:0] PCE,
    input  logic [PC_W-1:0] PCPlus4E,
    input  logic [4:0]      RdE,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            JumpE,
    input  logic            BranchE,
    input  logic            ALUSrcE,
    input  logic [1:0]      ResultSrcE,
    input  logic [2:0]      ALUControlE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [4:0]      RdM,
    output logic [PC_W-1:0] PCPlus4M,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic            PCSrcE,
    output logic [PC_W-1:0] PCTargetE,
    output logic            BusyE
);

    logic [XLEN-1:0] src_a_s;
    logic [XLEN-1:0] write_data_s;
    logic [XLEN-1:0] src_b_s;
    logic [XLEN-1:0] alu_res_s;
    logic [XLEN-1:0] ex_res_s;
    logic            zero_s;
    logic            busy_s;

    logic [XLEN-1:0] alu_result_q, alu_result_d;
    logic [XLEN-1:0] write_data_q, write_data_d;
    logic [4:0]      rd_q, rd_d;
    logic [PC_W-1:0] pc_plus4_q, pc_plus4_d;
    logic            reg_write_q, reg_write_d;
    logic            mem_write_q, mem_write_d;
    logic [1:0]      result_src_q, result_src_d;

    // Operand forwarding; encoding 11 falls back to the register operand.
    always_comb begin
        case (ForwardAE)
            FWD_WB:  src_a_s = ResultW;
            FWD_MEM: src_a_s = alu_result_q;
            default: src_a_s = RD1E;
        endcase
        case (ForwardBE)
            FWD_WB:  write_data_s = ResultW;
            FWD_MEM: write_data_s = alu_result_q;
            default: write_data_s = RD2E;
        endcase
        if (ALUSrcE) begin
            src_b_s = ImmExtE;
        end else begin
            src_b_s = write_data_s;
        end
    end

    alu_core #(.XLEN(XLEN)) u_alu (
        .a_i      (src_a_s),
        .b_i      (src_b_s),
        .op_i     (ALUControlE),
        .result_o (alu_res_s),
        .zero_o   (zero_s)
    );

    assign PCSrcE    = JumpE | (BranchE & zero_s);
    assign PCTargetE = PCE + ImmExtE[PC_W-1:0];
    assign BusyE     = busy_s;

`ifdef EXEC_MUL_EN
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

    mul_state_e      state_q, state_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Multiplier sequencing: operands captured at issue, one shift-add per MUL cycle.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_s   = 1'b0;
        ex_res_s = alu_res_s;
        case (state_q)
            ST_IDLE: begin
                if ((ALUControlE == ALU_MUL) && !reset) begin
                    busy_s   = 1'b1;
                    state_d  = ST_MUL;
                    mcand_d  = src_a_s;
                    mplier_d = src_b_s;
                    acc_d    = '0;
                    cnt_d    = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                busy_s = 1'b1;
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_DONE: begin
                // E still holds the mul; hand the product to M and do not reissue.
                ex_res_s = acc_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Multiplier state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end
`else
    assign busy_s   = 1'b0;
    assign ex_res_s = alu_res_s;
`endif

    // E/M next value: a bubble while the stage is stalled.
    always_comb begin
        if (busy_s) begin
            alu_result_d = '0;
            write_data_d = '0;
            rd_d         = 5'd0;
            pc_plus4_d   = '0;
            reg_write_d  = 1'b0;
            mem_write_d  = 1'b0;
            result_src_d = RES_ALU;
        end else begin
            alu_result_d = ex_res_s;
            write_data_d = write_data_s;
            rd_d         = RdE;
            pc_plus4_d   = PCPlus4E;
            reg_write_d  = RegWriteE;
            mem_write_d  = MemWriteE;
            result_src_d = ResultSrcE;
        end
    end

    // E/M pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_result_q <= '0;
            write_data_q <= '0;
            rd_q         <= 5'd0;
            pc_plus4_q   <= '0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= 2'b00;
        end else begin
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            rd_q         <= rd_d;
            pc_plus4_q   <= pc_plus4_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
        end
    end

    assign ALUResultM = alu_result_q;
    assign WriteDataM = write_data_q;
    assign RdM        = rd_q;
    assign PCPlus4M   = pc_plus4_q;
    assign RegWriteM  = reg_write_q;
    assign MemWriteM  = mem_write_q;
    assign ResultSrcM = result_src_q;

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the five-stage RV32 pipelined core, sitting directly downstream of the Decode/Execute pipeline register and upstream of memory. It resolves forwarded operands, runs the ALU, resolves branches and jumps (PCSrcE, PCTargetE), and holds the Execute/Memory pipeline register. An optional iterative multiplier makes the stage multi-cycle and raises a stall request to the hazard unit.

## Interface
Parameters:
- PC_W, 5, width of PC, PCPlus4 and branch-target fields.
- XLEN, 32, datapath width.

Ports (one clock, `clk`; reset `reset` is asynchronous, active-high):
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-high reset.
- RD1E, RD2E  in  XLEN  register operands from the D/E register.
- PCE, PCPlus4E  in  PC_W  instruction PC and PC+4.
- RdE  in  5  destination register.
- ImmExtE  in  XLEN  extended immediate.
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  in  1  control.
- ResultSrcE  in  2  result select.
- ALUControlE  in  3  ALU operation.
- ForwardAE, ForwardBE  in  2  operand source: 00 RDxE, 01 ResultW, 10 ALUResultM.
- ResultW  in  XLEN  write-back value.
- ALUResultM  out  XLEN  registered ALU result (also the forwarding source).
- WriteDataM  out  XLEN  registered forwarded SrcB before immediate mux (store data).
- RdM  out  5; PCPlus4M  out  PC_W; RegWriteM, MemWriteM  out  1; ResultSrcM  out  2.
- PCSrcE  out  1  redirect fetch; PCTargetE  out  PC_W  branch/jump target.
- BusyE  out  1  stall request (stall F, D, E; bubble into M).

## Operation
- SrcAE = mux(ForwardAE); WriteDataE = mux(ForwardBE); SrcBE = ALUSrcE ? ImmExtE : WriteDataE. Encoding 11 selects RDxE.
- ALUControlE: 000 add, 001 sub, 010 and, 011 or, 101 slt (signed, result 0/1), 111 mul (only with macro). Others: result 0. All arithmetic modulo 2^XLEN.
- ZeroE = (ALU result == 0). PCSrcE = JumpE | (BranchE & ZeroE). PCTargetE = PCE + ImmExtE[PC_W-1:0], wraps modulo 2^PC_W.
- E/M register loads every edge when BusyE=0: ALU result, WriteDataE, RdE, PCPlus4E, RegWriteE, ResultSrcE, MemWriteE.
- When BusyE=1: E/M loads a bubble (RegWriteM=MemWriteM=0, ResultSrcM=00, other fields 0).
- Flushing of the stage input is the D/E register's job; this block has no flush input.

## Timing
- Reset: all M outputs 0, FSM IDLE, counter 0, BusyE 0. Reset mid-multiply aborts without writing M.
- Single-cycle ops: result visible on M outputs one edge after instruction is in E. PCSrcE/PCTargetE combinational in the E cycle.
- Multiplier FSM (macro on): IDLE -> MUL when ALUControlE==111 (BusyE=1 combinationally in that cycle; operands SrcAE/SrcBE latched on the edge). MUL: one shift-add step per cycle, 32 steps, BusyE=1. After step 32 -> DONE: BusyE=0, E/M loads low XLEN bits of product with the held E control fields; -> IDLE.
- Multiply occupancy in E: 34 cycles (issue + 32 + DONE); result on M at the edge ending DONE.
- Back-to-back mul: DONE returns to IDLE; the next mul issues in the following cycle it is in E.
- Forward selects are ignored after issue (operands held internally).

## Configuration
- EXEC_MUL_EN defined: multiplier FSM and op 111 present.
- Undefined: op 111 yields 0 in one cycle, BusyE tied 0, no FSM state.

## Structure
- Package exec_pkg: ALU op codes, forward-select encodings, ResultSrc encodings, FSM state enum.
- Sub-module alu_core: combinational ALU (add/sub/and/or/slt, Zero). Forwarding muxes, branch logic, FSM and E/M register stay in execute_stage.

## Test plan
- Reset asserted asynchronously mid-cycle -> all M outputs 0, BusyE 0 immediately.
- add RD1E=5, RD2E=7, ALUSrcE=0, Forward 00 -> ALUResultM=12 next edge; sub 5-7 -> 0xFFFFFFFE; slt -1<1 -> 1.
- ForwardAE=10 with ALUResultM=100, ForwardBE=01 with ResultW=3, op add -> 103; WriteDataM=3.
- beq: BranchE=1, equal operands, PCE=8, ImmExtE=-4 -> PCSrcE=1, PCTargetE=4; PCE=30, Imm=4 -> PCTargetE=2 (wrap).
- EXEC_MUL_EN: mul 0x0001_0003 × 0x0002_0005 -> BusyE high 33 cycles, M bubbles meanwhile, then ALUResultM=0x000B_000F with RegWriteM=1.
- EXEC_MUL_EN: reset asserted at step 10 of multiply -> M stays 0, FSM IDLE, BusyE 0.
